pwm_reg_sequencer: RTL
======================

// Module: pwm_reg_sequencer
// PURPOSE
//  AHB-Lite master that shares the PWM peripheral register file (en, clkdiv, period0-7, duty0-7 at byte offsets 0x00-0x44)
//  between NREQ local requesters. Round-robin arbitration, one single-beat 32-bit AHB transfer per grant.
//  Per-requester handshake: gnt -> done (+ rdata/err). Sits between firmware/HW controllers and the PWM slave.
// PARAMETERS
//  NREQ        4        number of requesters (2..8)
//  BASE_ADDR   32'h0    PWM slave base; haddr = BASE_ADDR | {24'h0, offset}
//  TIMEOUT     16       max cycles in WAIT_LO+WAIT_HI before abort (used only with PWM_SEQ_TIMEOUT_EN)
// PORTS
//  I_ahb_clk      in   1         single clock, all logic posedge
//  I_rst          in   1         synchronous reset, active-high
//  I_req          in   NREQ      request level per requester; hold until O_req_done[i]
//  I_req_wr       in   NREQ      1=write, 0=read, per requester
//  I_req_addr     in   NREQ*8    register byte offset per requester, slice [8i+7:8i]
//  I_req_wdata    in   NREQ*32   write data per requester, slice [32i+31:32i]
//  O_req_gnt      out  NREQ      one-hot, high from ADDR through DONE for the granted requester
//  O_req_done     out  NREQ      one-cycle pulse to granted requester at transfer end
//  O_req_rdata    out  32        read data, valid with O_req_done (reads), held until next read
//  O_req_err      out  1         high with O_req_done when transfer aborted or offset illegal
//  O_busy         out  1         state != IDLE
//  O_ahb_htrans   out  2         2'b10 NONSEQ in ADDR only, else 2'b00
//  O_ahb_hwrite   out  1         registered with haddr
//  O_ahb_haddr    out  32        address phase
//  O_ahb_hsize    out  3         constant 3'b010
//  O_ahb_hburst   out  3         constant 3'b000
//  O_ahb_hwdata   out  32        data phase (valid from cycle after ADDR until DONE)
//  I_ahb_hready   in   1         slave ready
//  I_ahb_hrdata   in   32        slave read data
// BEHAVIOUR
//  Reset (sync, I_rst=1 at posedge): state=IDLE, rr pointer=0, htrans=00, hwrite=0, haddr=0, hwdata=0,
//   gnt=0, done=0, rdata=0, err=0, busy=0. Reset mid-transfer abandons it: no done pulse.
//  FSM: IDLE -> ADDR -> WAIT_LO -> WAIT_HI -> DONE -> IDLE.
//   IDLE: if any I_req, pick first set bit at or above ptr (wrapping); latch index, wr, offset, wdata.
//    Offset check: offset[1:0]!=0 or offset>0x44 -> go straight to DONE with err=1, no AHB traffic.
//   ADDR (1 cycle): htrans=NONSEQ, haddr/hwrite driven. Never NONSEQ for more than one cycle.
//   WAIT_LO: hwdata driven; wait for hready=0 (slave acknowledges). Then WAIT_HI.
//   WAIT_HI: wait for hready=1; on that cycle capture hrdata if read. -> DONE.
//   DONE (1 cycle): done[idx]=1, err as computed; ptr <= idx+1 (mod NREQ). gnt drops on exit.
//  Min latency, legal offset: ADDR at T, hready low T+1, high T+3 -> DONE at T+4; done pulse at T+4.
//  At least one IDLE cycle (htrans=00) between back-to-back transfers.
//  Requests rising during a transfer wait; a requester whose I_req falls before done is still serviced
//   (latched at grant). I_req[i] high in the DONE cycle of requester i is treated as a new request.
//  rdata unchanged on writes and on errored reads.
// CONFIGURATION
//  PWM_SEQ_TIMEOUT_EN defined: cycle counter (width clog2(TIMEOUT+1)) cleared in ADDR, counts in WAIT_LO/WAIT_HI;
//   reaching TIMEOUT -> DONE with err=1, htrans held 00.
//  Not defined: no counter, WAIT_LO/WAIT_HI wait indefinitely; O_req_err only for illegal offsets.
// TESTING
//  1 Write: req0 wr offset 0x28 data 0x0000_0032 -> NONSEQ 1 cycle, haddr=BASE|0x28, hwdata=0x32, done[0] 4 cycles after ADDR, err=0.
//  2 Read-back: req1 read 0x28 after test1 -> rdata=0x0000_0032 with done[1].
//  3 Round-robin: req0..3 all held high -> grants 0,1,2,3,0 in order, one IDLE cycle between NONSEQs.
//  4 Illegal offset 0x46 and 0x48 -> done+err=1 one cycle after grant, htrans stays 00, rdata unchanged.
//  5 Reset mid-op: assert I_rst in WAIT_HI -> next cycle all outputs at reset values, no done pulse, ptr=0.
//  6 With PWM_SEQ_TIMEOUT_EN, TIMEOUT=16, hready tied 1 -> err=1 with done exactly 16 cycles after ADDR; without macro busy stays 1.

Source files
------------

// File: rtl/pwm_reg_sequencer_if.sv
// AHB-Lite single-master bus bundle between pwm_reg_sequencer and the PWM register slave.
// The master modport is the sequencer's side; the slave modport is the register file's side.
interface pwm_reg_sequencer_if;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [31:0] haddr;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [31:0] hwdata;
    logic        hready;
    logic [31:0] hrdata;

    modport master (
        output htrans, hwrite, haddr, hsize, hburst, hwdata,
        input  hready, hrdata
    );

    modport slave (
        input  htrans, hwrite, haddr, hsize, hburst, hwdata,
        output hready, hrdata
    );
endinterface

// File: rtl/pwm_reg_sequencer.sv
// Round-robin AHB-Lite master sharing the PWM register file between NREQ requesters.
// Optional transfer abort after TIMEOUT cycles is enabled by defining PWM_SEQ_TIMEOUT_EN.
module pwm_reg_sequencer #(
    parameter int          NREQ      = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int          TIMEOUT   = 16
) (
    input  logic                 I_ahb_clk,
    input  logic                 I_rst,
    input  logic [NREQ-1:0]      I_req,
    input  logic [NREQ-1:0]      I_req_wr,
    input  logic [NREQ*8-1:0]    I_req_addr,
    input  logic [NREQ*32-1:0]   I_req_wdata,
    output logic [NREQ-1:0]      O_req_gnt,
    output logic [NREQ-1:0]      O_req_done,
    output logic [31:0]          O_req_rdata,
    output logic                 O_req_err,
    output logic                 O_busy,
    pwm_reg_sequencer_if.master  ahb
);

    localparam int          IDXW     = $clog2(NREQ);
    localparam logic [1:0]  HT_IDLE  = 2'b00;
    localparam logic [1:0]  HT_NSEQ  = 2'b10;
    localparam logic [7:0]  LAST_OFF = 8'h44;

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_WAIT_LO, S_WAIT_HI, S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [IDXW-1:0]   ptr_q, ptr_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              wr_q, wr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [1:0]        htrans_q, htrans_d;
    logic              hwrite_q, hwrite_d;
    logic [31:0]       haddr_q, haddr_d;
    logic [31:0]       hwdata_q, hwdata_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;

    // Arbitration result for the current IDLE cycle.
    logic              any_req, hi_hit;
    logic [IDXW-1:0]   hi_idx, lo_idx, pick_idx;
    logic              sel_wr;
    logic [7:0]        sel_off;
    logic [31:0]       sel_wdata;
    logic              sel_legal;
    logic              tmo_hit;

`ifdef PWM_SEQ_TIMEOUT_EN
    localparam int CNTW = $clog2(TIMEOUT + 1);
    logic [CNTW-1:0] cnt_q, cnt_d;

    // Counter is cleared in ADDR, so hitting TIMEOUT-2 here lands DONE exactly TIMEOUT cycles after ADDR.
    assign tmo_hit = (cnt_q == CNTW'(TIMEOUT - 2));

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == S_ADDR)
            cnt_d = '0;
        else if (state_q == S_WAIT_LO || state_q == S_WAIT_HI)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge I_ahb_clk) begin
        if (I_rst) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // First requester at or above ptr wins; otherwise wrap to the lowest requester.
    always_comb begin
        any_req = 1'b0;
        hi_hit  = 1'b0;
        hi_idx  = '0;
        lo_idx  = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (I_req[i]) begin
                any_req = 1'b1;
                lo_idx  = IDXW'(i);
                if (IDXW'(i) >= ptr_q) begin
                    hi_hit = 1'b1;
                    hi_idx = IDXW'(i);
                end
            end
        end
        pick_idx = hi_hit ? hi_idx : lo_idx;

        sel_wr    = 1'b0;
        sel_off   = '0;
        sel_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (IDXW'(i) == pick_idx) begin
                sel_wr    = I_req_wr[i];
                sel_off   = I_req_addr[8*i +: 8];
                sel_wdata = I_req_wdata[32*i +: 32];
            end
        end
        sel_legal = (sel_off[1:0] == 2'b00) && (sel_off <= LAST_OFF);
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
        state_d  = state_q;
        ptr_d    = ptr_q;
        idx_d    = idx_q;
        wr_d     = wr_q;
        wdata_d  = wdata_q;
        htrans_d = HT_IDLE;
        hwrite_d = hwrite_q;
        haddr_d  = haddr_q;
        hwdata_d = hwdata_q;
        gnt_d    = gnt_q;
        done_d   = '0;
        rdata_d  = rdata_q;
        err_d    = 1'b0;
        busy_d   = busy_q;

        unique case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    idx_d           = pick_idx;
                    wr_d            = sel_wr;
                    wdata_d         = sel_wdata;
                    gnt_d           = '0;
                    gnt_d[pick_idx] = 1'b1;
                    busy_d          = 1'b1;
                    if (sel_legal) begin
                        state_d  = S_ADDR;
                        htrans_d = HT_NSEQ;
                        hwrite_d = sel_wr;
                        haddr_d  = BASE_ADDR | {24'h0, sel_off};
                    end else begin
                        state_d          = S_DONE;
                        done_d[pick_idx] = 1'b1;
                        err_d            = 1'b1;
                    end
                end
            end
            S_ADDR: begin
                state_d = S_WAIT_LO;
                if (wr_q) hwdata_d = wdata_q;
            end
            S_WAIT_LO: begin
                if (tmo_hit) begin
                    state_d       = S_DONE;
                    done_d[idx_q] = 1'b1;
                    err_d         = 1'b1;
                end else if (!ahb.hready) begin
                    state_d = S_WAIT_HI;
                end
            end
            S_WAIT_HI: begin
                // A slave completing on the abort cycle still counts as a good transfer.
                if (ahb.hready) begin
                    state_d       = S_DONE;
                    done_d[idx_q] = 1'b1;
                    if (!wr_q) rdata_d = ahb.hrdata;
                end else if (tmo_hit) begin
                    state_d       = S_DONE;
                    done_d[idx_q] = 1'b1;
                    err_d         = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                ptr_d   = (idx_q == IDXW'(NREQ - 1)) ? '0 : idx_q + 1'b1;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge I_ahb_clk) begin
        // NOTE: state elements use non-blocking assignments so every flop samples pre-edge values.
        if (I_rst) begin
            state_q  <= S_IDLE;
            ptr_q    <= '0;
            idx_q    <= '0;
            wr_q     <= 1'b0;
            wdata_q  <= '0;
            htrans_q <= HT_IDLE;
            hwrite_q <= 1'b0;
            haddr_q  <= '0;
            hwdata_q <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            idx_q    <= idx_d;
            wr_q     <= wr_d;
            wdata_q  <= wdata_d;
            htrans_q <= htrans_d;
            hwrite_q <= hwrite_d;
            haddr_q  <= haddr_d;
            hwdata_q <= hwdata_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
        end
    end

    assign ahb.htrans  = htrans_q;
    assign ahb.hwrite  = hwrite_q;
    assign ahb.haddr   = haddr_q;
    assign ahb.hsize   = 3'b010;
    assign ahb.hburst  = 3'b000;
    assign ahb.hwdata  = hwdata_q;

    assign O_req_gnt   = gnt_q;
    assign O_req_done  = done_q;
    assign O_req_rdata = rdata_q;
    assign O_req_err   = err_q;
    assign O_busy      = busy_q;

endmodule
